opl3_timers: RTL and testbench
==============================

// Module: opl3_timers
// PURPOSE
//  OPL3 Timer 1 / Timer 2 block. Consumes the registered start bits and the IRQ-reset strobe from the host register file.
//  Rising edges on the start bits reload the 8-bit up-counters from their presets.
//  Counters advance on sample-rate clk_en ticks. Overflows raise per-timer flags and a combined IRQ for the status port.
// PARAMETERS
//  TIMER1_TICK  4   clk_en pulses per Timer 1 count (80 us at 49.716 kHz)
//  TIMER2_TICK  16  clk_en pulses per Timer 2 count (320 us)
// PORTS
//  clk          in   1  system clock; single clock domain
//  reset_n      in   1  synchronous, active-low reset
//  clk_en       in   1  one-cycle sample-rate enable
//  t1_preset    in   8  Timer 1 reload value (reg 0x02)
//  t2_preset    in   8  Timer 2 reload value (reg 0x03)
//  st1          in   1  Timer 1 start level (reg 0x04 bit0)
//  st2          in   1  Timer 2 start level (reg 0x04 bit1)
//  mask_t1      in   1  Timer 1 flag mask (reg 0x04 bit6)
//  mask_t2      in   1  Timer 2 flag mask (reg 0x04 bit5)
//  irq_rst      in   1  one-cycle strobe: clear all flags (reg 0x04 bit7 write)
//  ft1          out  1  Timer 1 overflow flag (status bit6)
//  ft2          out  1  Timer 2 overflow flag (status bit5)
//  irq          out  1  ft1 | ft2 (status bit7)
//  irq_n        out  1  ~irq; active-low interrupt pin
// BEHAVIOUR
//  Reset (reset_n=0 at posedge clk):
//   - counters=0, prescalers=0, start history=0
//   - ft1=ft2=irq=0, irq_n=1
//   - Reset overrides every other event in that cycle, including a tick.
//  Start edge (per timer, checked every clk, not gated by clk_en):
//   - A rising edge is st=1 while last cycle's st was 0.
//   - On that edge: counter<=preset, prescaler<=0, running=1.
//   - The edge has priority over a coincident tick in the same cycle.
//  Stop: st=0 sets running=0.
//   - Counter and prescaler hold; no ticks; flags keep their values.
//  Prescaler (per timer): counts clk_en pulses only while running.
//   - At TICK-1 with clk_en=1: wrap to 0 and emit tick.
//  Tick:
//   - counter!=0xFF: counter<=counter+1.
//   - counter==0xFF: counter<=current preset (8-bit wrap). Flag<=1 unless mask=1.
//  Preset writes while running:
//   - They do not disturb the running count.
//   - The new value is used at the next reload.
//  Mask:
//   - mask=1 suppresses new flag sets only. A flag that is already set stays set.
//   - The counter keeps running and reloading regardless of mask.
//  irq_rst:
//   - Clears ft1 and ft2 on the next clk.
//   - Coincides with an overflow of a timer: that timer's flag is set (set wins). The other flag clears.
//  Outputs:
//   - All outputs are registered.
//   - A flag is visible 1 clk after the clk_en that caused the overflow.
//   - irq and irq_n follow the flags in that same cycle, so they are decoded from the next-state flags.
//  Overflow period: (256-preset)*TICK clk_en pulses.
//   - preset=0xFF gives an overflow every TICK pulses.
//   - preset=0x00 gives 256*TICK.
// TESTING
//  1. Timer 1 basic: TIMER1_TICK=4, t1_preset=0xFE; pulse st1 0->1.
//     - ft1=0 through the 7th clk_en.
//     - ft1=1, irq=1, irq_n=0 one clk after the 8th clk_en.
//  2. Timer 2 reload: t2_preset=0xFF, st2=1.
//     - ft2 first rises after the 16th clk_en.
//     - Then irq_rst; ft2 re-rises after the 32nd clk_en.
//  3. Mask: mask_t1=1, t1_preset=0xFF; run 40 clk_en.
//     - ft1 stays 0 throughout.
//     - Clear mask_t1; ft1=1 after 4 more clk_en.
//  4. Simultaneous: irq_rst asserted on the same clk as the Timer 1 overflow clk_en, with ft2=1 beforehand.
//     - Result: ft1=1, ft2=0, irq=1.
//  5. Stop and restart: stop Timer 1 mid-count at counter=0x80, wait 100 clk_en, then raise st1 again with preset=0x10.
//     - No flag while stopped.
//     - Counter restarts from 0x10, prescaler from 0.
//  6. Reset mid-operation: reset_n=0 for 1 clk while ft1=ft2=1 and both timers are running.
//     - Outputs return to ft1=ft2=irq=0, irq_n=1.
//     - Holding st1=1 through reset then re-raising it after reset restarts the timer.

Source files
------------

// File: rtl/opl3_timers_if.sv
// Host-side register signals for the OPL3 Timer 1 / Timer 2 block.
// The master side is the register file; the slave side is the timer block.
interface opl3_timers_if;
    logic       clk_en;
    logic [7:0] t1_preset;
    logic [7:0] t2_preset;
    logic       st1;
    logic       st2;
    logic       mask_t1;
    logic       mask_t2;
    logic       irq_rst;
    logic       ft1;
    logic       ft2;
    logic       irq;
    logic       irq_n;

    modport master (
        output clk_en, t1_preset, t2_preset, st1, st2, mask_t1, mask_t2, irq_rst,
        input  ft1, ft2, irq, irq_n
    );

    modport slave (
        input  clk_en, t1_preset, t2_preset, st1, st2, mask_t1, mask_t2, irq_rst,
        output ft1, ft2, irq, irq_n
    );
endinterface

// File: rtl/opl3_timers.sv
// OPL3 Timer 1 / Timer 2: prescaled 8-bit up-counters with overflow flags and IRQ.
//
// Per-timer run state:
//   state  | meaning
//   T_STOP | start bit low (or after reset); counter and prescaler hold
//   T_RUN  | start bit high since its rising edge; prescaler counts clk_en
//
// Index 0 is Timer 1, index 1 is Timer 2. The prescaler is a down-counter
// loaded with TICK-1; reaching zero on clk_en produces one counter tick.
module opl3_timers #(
    parameter int TIMER1_TICK = 4,
    parameter int TIMER2_TICK = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    opl3_timers_if.slave  bus
);
    localparam int TICK_MAX = (TIMER1_TICK > TIMER2_TICK) ? TIMER1_TICK : TIMER2_TICK;
    localparam int PRE_W    = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
    localparam logic [PRE_W-1:0] PRE_TOP1 = PRE_W'(TIMER1_TICK - 1);
    localparam logic [PRE_W-1:0] PRE_TOP2 = PRE_W'(TIMER2_TICK - 1);

    typedef enum logic {T_STOP = 1'b0, T_RUN = 1'b1} run_state_e;

    run_state_e       state_q [2];
    run_state_e       state_d [2];
    logic [7:0]       cnt_q   [2];
    logic [7:0]       cnt_d   [2];
    logic [PRE_W-1:0] pre_q   [2];
    logic [PRE_W-1:0] pre_d   [2];
    logic [1:0]       st_last_q, st_last_d;
    logic [1:0]       flag_q, flag_d;
    logic             irq_q, irq_d;
    logic             irq_n_q, irq_n_d;
    logic [1:0]       st;
    logic [1:0]       mask;
    logic [1:0]       ovf;

    assign st   = {bus.st2, bus.st1};
    assign mask = {bus.mask_t2, bus.mask_t1};

    // Next-state for both timers: start edge beats tick, stop freezes, overflow sets flag over irq_rst.
    always_comb begin
        ovf       = '0;
        flag_d    = flag_q;
        st_last_d = st;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            pre_d[i]   = pre_q[i];
            if (st[i] && !st_last_q[i]) begin
                state_d[i] = T_RUN;
                cnt_d[i]   = (i == 0) ? bus.t1_preset : bus.t2_preset;
                pre_d[i]   = (i == 0) ? PRE_TOP1 : PRE_TOP2;
            end else if (!st[i]) begin
                state_d[i] = T_STOP;
            end else if (state_q[i] == T_RUN && bus.clk_en) begin
                if (pre_q[i] == '0) begin
                    pre_d[i] = (i == 0) ? PRE_TOP1 : PRE_TOP2;
                    if (cnt_q[i] == 8'hFF) begin
                        // Preset is sampled here, so writes while running only affect this reload.
                        cnt_d[i] = (i == 0) ? bus.t1_preset : bus.t2_preset;
                        ovf[i]   = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 8'd1;
                    end
                end else begin
                    pre_d[i] = pre_q[i] - 1'b1;
                end
            end
            if (ovf[i] && !mask[i]) begin
                flag_d[i] = 1'b1;
            end else if (bus.irq_rst) begin
                flag_d[i] = 1'b0;
            end
        end
        // Decoded from next-state flags so irq changes in the same cycle as the flags.
        irq_d   = |flag_d;
        irq_n_d = ~irq_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= '{T_STOP, T_STOP};
            cnt_q     <= '{default: '0};
            pre_q     <= '{default: '0};
            st_last_q <= '0;
            flag_q    <= '0;
            irq_q     <= 1'b0;
            irq_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_q     <= pre_d;
            st_last_q <= st_last_d;
            flag_q    <= flag_d;
            irq_q     <= irq_d;
            irq_n_q   <= irq_n_d;
        end
    end

    assign bus.ft1   = flag_q[0];
    assign bus.ft2   = flag_q[1];
    assign bus.irq   = irq_q;
    assign bus.irq_n = irq_n_q;
endmodule

// File: tb/tb_opl3_timers.sv
// Bench for opl3_timers: directed scenarios plus a randomized phase, all checked
// cycle-by-cycle against a pulse-counting model of the overflow period.
module tb_opl3_timers;
    localparam int T1 = 4;
    localparam int T2 = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    opl3_timers_if b ();

    opl3_timers #(.TIMER1_TICK(T1), .TIMER2_TICK(T2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model: each running timer counts clk_en pulses since its last reload and
    // overflows when that count reaches (256 - loaded value) * TICK.
    bit m_run  [2];
    bit m_last [2];
    int m_ld   [2];
    int m_pul  [2];
    bit m_f    [2];

    task automatic model_step();
        bit st_i, mask_i, ovf_i;
        int pre_i, tick_i;
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                m_run[i] = 0; m_last[i] = 0; m_ld[i] = 0; m_pul[i] = 0; m_f[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            st_i   = (i == 0) ? b.st1 : b.st2;
            mask_i = (i == 0) ? b.mask_t1 : b.mask_t2;
            pre_i  = (i == 0) ? int'(b.t1_preset) : int'(b.t2_preset);
            tick_i = (i == 0) ? T1 : T2;
            ovf_i  = 0;
            if (st_i && !m_last[i]) begin
                m_run[i] = 1; m_ld[i] = pre_i; m_pul[i] = 0;
            end else if (!st_i) begin
                m_run[i] = 0;
            end else if (m_run[i] && b.clk_en) begin
                m_pul[i]++;
                if (m_pul[i] == (256 - m_ld[i]) * tick_i) begin
                    ovf_i = 1; m_ld[i] = pre_i; m_pul[i] = 0;
                end
            end
            m_last[i] = st_i;
            if (ovf_i && !mask_i) m_f[i] = 1;
            else if (b.irq_rst)   m_f[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        chk("ft1",   b.ft1,   m_f[0]);
        chk("ft2",   b.ft2,   m_f[1]);
        chk("irq",   b.irq,   m_f[0] | m_f[1]);
        chk("irq_n", b.irq_n, ~(m_f[0] | m_f[1]));
    endtask

    task automatic pulses(input int n);
        for (int k = 0; k < n; k++) begin
            b.clk_en = 1'b1;
            cyc();
        end
        b.clk_en = 1'b0;
    endtask

    task automatic clear_irq();
        b.irq_rst = 1'b1;
        cyc();
        b.irq_rst = 1'b0;
    endtask

    initial begin
        b.clk_en = 0; b.t1_preset = 0; b.t2_preset = 0; b.st1 = 0; b.st2 = 0;
        b.mask_t1 = 0; b.mask_t2 = 0; b.irq_rst = 0;

        // Reset state
        reset_n = 0;
        cyc(); cyc();
        chk("rst_ft1", b.ft1, 1'b0);
        chk("rst_irq_n", b.irq_n, 1'b1);
        reset_n = 1;
        cyc();

        // Timer 1 basic: preset 0xFE overflows on the 8th clk_en
        b.t1_preset = 8'hFE; b.st1 = 1;
        cyc();
        pulses(7);
        chk("t1_before_8th", b.ft1, 1'b0);
        pulses(1);
        chk("t1_after_8th", b.ft1, 1'b1);
        chk("t1_irq", b.irq, 1'b1);
        chk("t1_irq_n", b.irq_n, 1'b0);
        clear_irq();
        chk("t1_cleared", b.ft1, 1'b0);
        b.st1 = 0;
        cyc();

        // Timer 2 reload: 0xFF overflows every 16 clk_en
        b.t2_preset = 8'hFF; b.st2 = 1;
        cyc();
        pulses(15);
        chk("t2_before_16th", b.ft2, 1'b0);
        pulses(1);
        chk("t2_after_16th", b.ft2, 1'b1);
        clear_irq();
        chk("t2_cleared", b.ft2, 1'b0);
        pulses(15);
        chk("t2_before_32nd", b.ft2, 1'b0);
        pulses(1);
        chk("t2_after_32nd", b.ft2, 1'b1);

        // Simultaneous irq_rst and Timer 1 overflow, ft2 already set
        b.t1_preset = 8'hFF; b.st1 = 1;
        cyc();
        pulses(3);
        chk("sim_pre_ft1", b.ft1, 1'b0);
        b.clk_en = 1; b.irq_rst = 1;
        cyc();
        b.clk_en = 0; b.irq_rst = 0;
        chk("sim_ft1", b.ft1, 1'b1);
        chk("sim_ft2", b.ft2, 1'b0);
        chk("sim_irq", b.irq, 1'b1);
        b.st1 = 0; b.st2 = 0;
        cyc();
        clear_irq();

        // Mask: no flag while masked, counting continues
        b.mask_t1 = 1; b.t1_preset = 8'hFF; b.st1 = 1;
        cyc();
        pulses(40);
        chk("mask_ft1", b.ft1, 1'b0);
        b.mask_t1 = 0;
        cyc();
        pulses(3);
        chk("unmask_early", b.ft1, 1'b0);
        pulses(1);
        chk("unmask_ft1", b.ft1, 1'b1);

        // Stop at counter 0x80, idle 100 clk_en, restart from preset 0x10
        b.st1 = 0;
        cyc();
        clear_irq();
        b.t1_preset = 8'h00; b.st1 = 1;
        cyc();
        pulses(512);
        b.st1 = 0;
        cyc();
        pulses(100);
        chk("stopped_ft1", b.ft1, 1'b0);
        b.t1_preset = 8'h10; b.st1 = 1;
        cyc();
        pulses(959);
        chk("restart_early", b.ft1, 1'b0);
        pulses(1);
        chk("restart_ovf", b.ft1, 1'b1);

        // Reset mid-operation with both flags set and both timers running
        b.t1_preset = 8'hFF; b.st2 = 1;
        cyc();
        pulses(16);
        chk("pre_rst_ft1", b.ft1, 1'b1);
        chk("pre_rst_ft2", b.ft2, 1'b1);
        reset_n = 0;
        cyc();
        reset_n = 1;
        chk("mid_rst_ft1", b.ft1, 1'b0);
        chk("mid_rst_ft2", b.ft2, 1'b0);
        chk("mid_rst_irq", b.irq, 1'b0);
        chk("mid_rst_irq_n", b.irq_n, 1'b1);
        b.st1 = 0;
        cyc();
        b.st1 = 1;
        cyc();
        pulses(3);
        chk("post_rst_early", b.ft1, 1'b0);
        pulses(1);
        chk("post_rst_ovf", b.ft1, 1'b1);

        // Randomized phase
        for (int n = 0; n < 6000; n++) begin
            b.clk_en  = ($urandom_range(0, 1) == 0);
            b.irq_rst = ($urandom_range(0, 39) == 0);
            reset_n   = ($urandom_range(0, 1999) != 0);
            if ($urandom_range(0, 149) == 0) b.st1 = ~b.st1;
            if ($urandom_range(0, 149) == 0) b.st2 = ~b.st2;
            if ($urandom_range(0, 99) == 0)  b.mask_t1 = ~b.mask_t1;
            if ($urandom_range(0, 99) == 0)  b.mask_t2 = ~b.mask_t2;
            if ($urandom_range(0, 49) == 0)  b.t1_preset = 8'($urandom_range(8'hE0, 8'hFF));
            if ($urandom_range(0, 49) == 0)  b.t2_preset = 8'($urandom_range(8'hF4, 8'hFF));
            cyc();
        end
        reset_n = 1; b.irq_rst = 0; b.clk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
